// File: rtl/sa_pkg.sv
// sa_pkg: shared array sizing and operand loader state encoding.
// Imported by operand_loader and its bench.
package sa_pkg;

  localparam int SA_N      = 8;
  localparam int SA_NREG   = 2 * SA_N;
  localparam int SA_DATA_W = 16;
  localparam int SA_REG_W  = $clog2(SA_NREG);
  localparam int SA_IDX_W  = $clog2(SA_N);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    LOAD,
    WAIT_MM,
    FIN
  } ld_state_e;

endpackage

// File: rtl/operand_loader.sv
// operand_loader: streams 2N*N operand words into the array register file.
// Define OPERAND_LOADER_TIMEOUT_EN to bound the WAIT_MM wait.
module operand_loader
  import sa_pkg::*;
#(
  parameter int DATA_W         = SA_DATA_W,
  parameter int N              = SA_N,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                CLK,
  input  logic                CLEAR_N,
  input  logic                START,
  input  logic                S_VALID,
  output logic                S_READY,
  input  logic [DATA_W-1:0]   S_DATA,
  input  logic                S_LAST,
  input  logic                INTERRUPT_IN,
  output logic                CHIP_EN,
  output logic                CHIP_WRITE,
  output logic                CHIP_LOAD,
  output logic [SA_REG_W-1:0] CHIP_REG_SELECT,
  output logic [SA_IDX_W-1:0] CHIP_IDX_SELECT,
  output logic [DATA_W-1:0]   CHIP_DATA_IN,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int CW = SA_REG_W + SA_IDX_W;
  localparam int NW = 2 * N * N;
  localparam logic [CW-1:0] LAST_CNT = CW'(NW - 1);

  ld_state_e           r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_wr;
  logic                r_load;
  logic                r_err;
  logic [SA_REG_W-1:0] r_reg;
  logic [SA_IDX_W-1:0] r_idx;
  logic [DATA_W-1:0]   r_data;

  logic w_acc;
  logic w_last;
  logic w_frame_ok;
  logic w_busy;

`ifdef OPERAND_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  assign w_acc      = (r_state == WRITE) && S_VALID;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_frame_ok = (w_last == S_LAST);
  assign w_busy     = (r_state != IDLE);

  assign S_READY         = (r_state == WRITE);
  assign BUSY            = w_busy;
  assign CHIP_EN         = w_busy;
  assign DONE            = (r_state == FIN);
  assign ERR             = r_err;
  assign CHIP_WRITE      = r_wr;
  assign CHIP_LOAD       = r_load;
  assign CHIP_REG_SELECT = r_reg;
  assign CHIP_IDX_SELECT = r_idx;
  assign CHIP_DATA_IN    = r_data;

  // Sequencer: frame counting, framing check, load and completion wait.
  always_ff @(posedge CLK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
`ifdef OPERAND_LOADER_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      r_load <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (START) begin
            r_state <= WRITE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        WRITE: begin
          if (w_acc) begin
            r_cnt <= r_cnt + CW'(1);
            if (!w_frame_ok) begin
              r_err   <= 1'b1;
              r_state <= FIN;
            end else if (w_last) begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          r_load  <= 1'b1;
          r_state <= WAIT_MM;
`ifdef OPERAND_LOADER_TIMEOUT_EN
          r_tmo   <= '0;
`endif
        end
        WAIT_MM: begin
          if (INTERRUPT_IN) begin
            r_state <= FIN;
          end
`ifdef OPERAND_LOADER_TIMEOUT_EN
          else if (r_tmo == TMO_LAST) begin
            r_err   <= 1'b1;
            r_state <= FIN;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
`endif
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Write port: one registered array write per accepted word.
  always_ff @(posedge CLK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      r_wr   <= 1'b0;
      r_reg  <= '0;
      r_idx  <= '0;
      r_data <= '0;
    end else begin
      r_wr <= w_acc;
      if (w_acc) begin
        r_reg  <= r_cnt[CW-1:SA_IDX_W];
        r_idx  <= r_cnt[SA_IDX_W-1:0];
        r_data <= S_DATA;
      end
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: random-stimulus bench with an event-level model.
// Timeout case runs only with OPERAND_LOADER_TIMEOUT_EN defined.
module tb_operand_loader;
  import sa_pkg::*;

  localparam int DW  = SA_DATA_W;
  localparam int NN  = SA_N;
  localparam int NW  = 2 * NN * NN;
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          CLEAR_N = 1'b1;
  logic          START = 1'b0;
  logic          S_VALID = 1'b0;
  logic          S_LAST = 1'b0;
  logic          INTERRUPT_IN = 1'b0;
  logic [DW-1:0] S_DATA = '0;
  logic          S_READY;
  logic          CHIP_EN;
  logic          CHIP_WRITE;
  logic          CHIP_LOAD;
  logic [3:0]    CHIP_REG_SELECT;
  logic [2:0]    CHIP_IDX_SELECT;
  logic [DW-1:0] CHIP_DATA_IN;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  int n_chk = 0;
  int n_err = 0;

  bit            m_busy, m_wr, m_wait, m_fin, m_err, m_ld;
  int            m_k, m_reg, m_idx;
  logic [DW-1:0] m_data;
  int            n_wr, n_ld;
`ifdef OPERAND_LOADER_TIMEOUT_EN
  int            m_wcnt;
`endif

  operand_loader #(
    .DATA_W(DW),
    .N(NN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK),
    .CLEAR_N(CLEAR_N),
    .START(START),
    .S_VALID(S_VALID),
    .S_READY(S_READY),
    .S_DATA(S_DATA),
    .S_LAST(S_LAST),
    .INTERRUPT_IN(INTERRUPT_IN),
    .CHIP_EN(CHIP_EN),
    .CHIP_WRITE(CHIP_WRITE),
    .CHIP_LOAD(CHIP_LOAD),
    .CHIP_REG_SELECT(CHIP_REG_SELECT),
    .CHIP_IDX_SELECT(CHIP_IDX_SELECT),
    .CHIP_DATA_IN(CHIP_DATA_IN),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_wait = 0; m_fin = 0; m_err = 0; m_ld = 0;
    m_k = 0; m_reg = 0; m_idx = 0; m_data = '0;
`ifdef OPERAND_LOADER_TIMEOUT_EN
    m_wcnt = 0;
`endif
  endtask

  task automatic check_outs(input bit exp_wr, input bit exp_ld);
    chk("s_ready", 32'(S_READY), 32'(m_wr));
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("chip_en", 32'(CHIP_EN), 32'(m_busy));
    chk("chip_write", 32'(CHIP_WRITE), 32'(exp_wr));
    chk("chip_load", 32'(CHIP_LOAD), 32'(exp_ld));
    chk("done", 32'(DONE), 32'(m_fin));
    chk("err", 32'(ERR), 32'(m_err));
    chk("reg_sel", 32'(CHIP_REG_SELECT), 32'(m_reg));
    chk("idx_sel", 32'(CHIP_IDX_SELECT), 32'(m_idx));
    chk("data_in", 32'(CHIP_DATA_IN), 32'(m_data));
  endtask

  // One clock: predict from pre-edge inputs, then check post-edge outputs.
  task automatic tick();
    bit st, acc, lst, irq, fin_now, ld, lastw;
    logic [DW-1:0] d;
    st      = START && !m_busy;
    acc     = m_wr && S_VALID;
    lst     = S_LAST;
    d       = S_DATA;
    irq     = m_wait && INTERRUPT_IN;
    fin_now = m_fin;
    @(posedge CLK);
    #1;
    if (CHIP_WRITE === 1'b1) n_wr++;
    if (CHIP_LOAD === 1'b1) n_ld++;
    if (!CLEAR_N) begin
      model_reset();
      check_outs(0, 0);
      return;
    end
    ld = m_ld;
    m_ld = 0;
    if (fin_now) begin
      m_fin = 0;
      m_busy = 0;
    end
    if (st) begin
      m_busy = 1; m_wr = 1; m_k = 0; m_err = 0;
    end
    if (m_wait) begin
      if (irq) begin
        m_wait = 0;
        m_fin = 1;
      end
`ifdef OPERAND_LOADER_TIMEOUT_EN
      else begin
        m_wcnt++;
        if (m_wcnt == TMO) begin
          m_wait = 0; m_fin = 1; m_err = 1;
        end
      end
`endif
    end
    if (ld) begin
      m_wait = 1;
`ifdef OPERAND_LOADER_TIMEOUT_EN
      m_wcnt = 0;
`endif
    end
    if (acc) begin
      m_reg  = m_k / NN;
      m_idx  = m_k % NN;
      m_data = d;
      lastw  = (m_k == NW - 1);
      if (lst != lastw) begin
        m_err = 1; m_wr = 0; m_fin = 1;
      end else if (lastw) begin
        m_wr = 0; m_ld = 1;
      end
      m_k++;
    end
    check_outs(acc, ld);
    if (acc && m_k == 10 && d == DW'(9)) begin
      chk("w9_reg", 32'(CHIP_REG_SELECT), 32'd1);
      chk("w9_idx", 32'(CHIP_IDX_SELECT), 32'd1);
      chk("w9_data", 32'(CHIP_DATA_IN), 32'd9);
    end
  endtask

  task automatic hit_reset();
    CLEAR_N = 1'b0;
    #1;
    model_reset();
    check_outs(0, 0);
    tick();
    tick();
    CLEAR_N = 1'b1;
    tick();
  endtask

  task automatic go();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // mode 0: value i every cycle, 1: valid every other cycle, 2: random.
  task automatic feed(input int mode, input int last_at, input int abort_at,
                      input bit inj);
    int g;
    bit injd;
    g = 0;
    injd = 0;
    while (m_wr && g < 4000) begin
      case (mode)
        0:       S_VALID = 1'b1;
        1:       S_VALID = (g[0] == 1'b0);
        default: S_VALID = 1'($urandom_range(0, 1));
      endcase
      S_DATA = (mode == 0) ? DW'(m_k) : DW'($urandom);
      S_LAST = (m_k == last_at);
      if (inj && !injd && m_k == 30) begin
        START = 1'b1;
        INTERRUPT_IN = 1'b1;
        injd = 1;
      end
      tick();
      START = 1'b0;
      INTERRUPT_IN = 1'b0;
      if (abort_at >= 0 && m_k > abort_at) begin
        S_VALID = 1'b0;
        hit_reset();
        break;
      end
      g++;
    end
    chk("feed_bound", 32'(g < 4000), 32'd1);
    S_VALID = 1'b0;
    S_LAST = 1'b0;
  endtask

  // irq_delay < 0 leaves INTERRUPT_IN low until the timeout ends the run.
  task automatic complete(input int irq_delay);
    int g;
    g = 0;
    while (!m_wait && m_busy && g < 10) begin
      tick();
      g++;
    end
    if (m_wait && irq_delay >= 0) begin
      repeat (irq_delay) tick();
      INTERRUPT_IN = 1'b1;
      tick();
      INTERRUPT_IN = 1'b0;
    end
    g = 0;
    while (m_busy && g < 200) begin
      tick();
      g++;
    end
    chk("idle_bound", 32'(g < 200), 32'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    n_wr = 0;
    n_ld = 0;
    #2;
    CLEAR_N = 1'b0;
    #1;
    check_outs(0, 0);
    tick();
    CLEAR_N = 1'b1;
    tick();

    n_wr = 0; n_ld = 0;
    go();
    feed(0, NW - 1, -1, 0);
    complete(int'($urandom_range(0, 8)));
    chk("s1_writes", 32'(n_wr), 32'(NW));
    chk("s1_loads", 32'(n_ld), 32'd1);
    chk("s1_err", 32'(ERR), 32'd0);

    n_wr = 0; n_ld = 0;
    go();
    feed(1, NW - 1, -1, 0);
    complete(int'($urandom_range(0, 8)));
    chk("s2_writes", 32'(n_wr), 32'(NW));

    n_wr = 0; n_ld = 0;
    go();
    feed(2, 40, -1, 0);
    complete(3);
    chk("s3_err", 32'(ERR), 32'd1);
    chk("s3_loads", 32'(n_ld), 32'd0);
    chk("s3_writes", 32'(n_wr), 32'd41);
    go();
    chk("s3_err_clr", 32'(ERR), 32'd0);
    feed(2, NW - 1, -1, 0);
    complete(int'($urandom_range(0, 8)));

    n_ld = 0;
    go();
    feed(2, -1, -1, 0);
    complete(0);
    chk("s4_err", 32'(ERR), 32'd1);
    chk("s4_loads", 32'(n_ld), 32'd0);

    go();
    feed(0, NW - 1, 70, 0);
    chk("s5_busy", 32'(BUSY), 32'd0);
    n_wr = 0;
    go();
    S_VALID = 1'b1;
    S_DATA = DW'(16'h5a5a);
    tick();
    chk("s5_reg0", 32'(CHIP_REG_SELECT), 32'd0);
    chk("s5_idx0", 32'(CHIP_IDX_SELECT), 32'd0);
    feed(2, NW - 1, -1, 0);
    complete(int'($urandom_range(0, 8)));
    chk("s5_writes", 32'(n_wr), 32'(NW));

    n_wr = 0; n_ld = 0;
    go();
    feed(2, NW - 1, -1, 1);
    complete(int'($urandom_range(0, 8)));
    chk("s6_writes", 32'(n_wr), 32'(NW));
    chk("s6_loads", 32'(n_ld), 32'd1);
    chk("s6_err", 32'(ERR), 32'd0);

`ifdef OPERAND_LOADER_TIMEOUT_EN
    go();
    feed(2, NW - 1, -1, 0);
    complete(-1);
    chk("s7_tmo_err", 32'(ERR), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand word width.
REQ-002 SHALL have parameter N, default 8, array dimension: 2N registers of N entries each.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum wait for matmul completion.
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port CLEAR_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port START  in  1  begin load sequence, single-cycle pulse.
REQ-007 SHALL have ports S_VALID in 1, S_READY out 1, S_DATA in DATA_W, S_LAST in 1: operand stream, valid/ready handshake.
REQ-008 SHALL have port INTERRUPT_IN  in  1  matmul-complete flag from array top.
REQ-009 SHALL have ports CHIP_EN, CHIP_WRITE, CHIP_LOAD (out 1 each), CHIP_REG_SELECT (out 4), CHIP_IDX_SELECT (out 3) and CHIP_DATA_IN (out DATA_W), all driving the array top's EN, AUX and DATA_IN inputs.
REQ-010 SHALL have ports BUSY, DONE and ERR, out 1 each, status.

Function
REQ-011 SHALL implement states IDLE, WRITE, LOAD, WAIT_MM and FIN.
REQ-012 SHALL go IDLE->WRITE on START and SHALL clear ERR and the word counter on that transition; START outside IDLE is ignored.
REQ-013 SHALL assert S_READY only in WRITE and accept a word on S_VALID&&S_READY.
REQ-014 SHALL register each accepted word with 1-cycle latency: CHIP_WRITE=1, CHIP_DATA_IN=S_DATA, CHIP_REG_SELECT=cnt[6:3], CHIP_IDX_SELECT=cnt[2:0], where cnt is a 7-bit accepted-word count.
REQ-015 SHALL drive CHIP_WRITE=0 in every cycle that follows a non-accepting cycle; CHIP_REG_SELECT, CHIP_IDX_SELECT and CHIP_DATA_IN hold their last values.
REQ-016 SHALL map words 0..63 to activation registers 0..7, row-major, and words 64..127 to transposed-weight registers 8..15.
REQ-017 SHALL go WRITE->LOAD when word 127 is accepted with S_LAST=1.
REQ-018 SHALL treat S_LAST=1 on word<127, or S_LAST=0 on word 127, as a framing error: set ERR, skip LOAD, go to FIN.
REQ-019 SHALL assert CHIP_LOAD for exactly one cycle in LOAD with CHIP_WRITE=0, then go to WAIT_MM.
REQ-020 SHALL leave WAIT_MM for FIN on the first cycle INTERRUPT_IN=1.
REQ-021 SHALL pulse DONE=1 for one cycle in FIN, then return to IDLE.
REQ-022 SHALL hold ERR sticky until the next accepted START.
REQ-023 SHALL drive BUSY=1 in every state except IDLE, and CHIP_EN=BUSY.
REQ-024 SHALL ignore INTERRUPT_IN in any state other than WAIT_MM.

Reset
REQ-025 SHALL, while CLEAR_N=0, immediately force state IDLE, cnt=0, and all outputs to 0 (S_READY, CHIP_*, BUSY, DONE, ERR).
REQ-026 SHALL abort any in-flight sequence on reset mid-operation, issuing no further CHIP_WRITE or CHIP_LOAD.

Configuration
REQ-027 SHALL, with macro OPERAND_LOADER_TIMEOUT_EN defined, count cycles in WAIT_MM; on reaching TIMEOUT_CYCLES without INTERRUPT_IN it SHALL set ERR and go to FIN.
REQ-028 SHALL, without OPERAND_LOADER_TIMEOUT_EN, wait in WAIT_MM indefinitely, with no timeout counter synthesised.

Structure
REQ-029 SHALL take N, the register count (16), DATA_W and the state enum from shared package sa_pkg.
REQ-030 SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-031 Bench SHALL cover: reset, START, then 128 words of value i (S_LAST on word 127) -> 128 CHIP_WRITE pulses; word 9 lands at REG=1, IDX=1, DATA=9; one CHIP_LOAD; then INTERRUPT_IN=1 -> DONE pulse, ERR=0.
REQ-032 Bench SHALL cover: S_VALID toggled every other cycle -> CHIP_WRITE only in cycles following accepts, and address sequence contiguous 0..127.
REQ-033 Bench SHALL cover: S_LAST=1 on word 40 -> ERR=1, no CHIP_LOAD, DONE pulse, IDLE; the next START clears ERR.
REQ-034 Bench SHALL cover: CLEAR_N low after word 70 -> outputs 0 immediately; a new START restarts at REG=0, IDX=0.
REQ-035 Bench SHALL cover, with OPERAND_LOADER_TIMEOUT_EN defined: INTERRUPT_IN held 0 -> ERR=1 and DONE pulse exactly TIMEOUT_CYCLES after entering WAIT_MM.
REQ-036 Bench SHALL cover: START pulsed during WRITE and INTERRUPT_IN pulsed during WRITE -> both ignored, with sequence and counter unaffected.
